// File: rtl/sequential_multiplier.sv
// sequential_multiplier: radix-2 shift-add multiplier, signed/unsigned, valid/ready handshakes.
// Optional early termination on a zero shifted multiplier: define SEQ_MULT_EARLY_EXIT_EN.
`default_nettype none

module sequential_multiplier #(
  parameter int WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 resetN,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  input  logic                 signedMode,
  input  logic                 inValid,
  output logic                 inReady,
  output logic [2*WIDTH-1:0]   product,
  output logic                 outValid,
  input  logic                 outReady,
  output logic                 busy
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam int PW = 2 * WIDTH;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_FIX  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [PW-1:0]    r_mcand;
  logic [PW-1:0]    r_acc;
  logic [WIDTH-1:0] r_mplier;
  logic             r_sign;
  logic [CW-1:0]    r_cnt;
  logic [PW-1:0]    r_product;
  logic             r_out_valid;

  logic             w_accept;
  logic             w_a_neg;
  logic             w_b_neg;
  logic [WIDTH-1:0] w_a_mag;
  logic [WIDTH-1:0] w_b_mag;
  logic [PW-1:0]    w_acc_add;
  logic [WIDTH-1:0] w_mplier_shift;
  logic             w_last;

  assign inReady  = (r_state == S_IDLE);
  assign busy     = (r_state != S_IDLE);
  assign product  = r_product;
  assign outValid = r_out_valid;

  assign w_accept = inValid && (r_state == S_IDLE);

  // Magnitudes are unsigned WIDTH-bit, so the most-negative operand maps to 2^(WIDTH-1) exactly.
  assign w_a_neg = signedMode & a[WIDTH-1];
  assign w_b_neg = signedMode & b[WIDTH-1];
  assign w_a_mag = w_a_neg ? (~a + WIDTH'(1)) : a;
  assign w_b_mag = w_b_neg ? (~b + WIDTH'(1)) : b;

  assign w_acc_add      = r_mplier[0] ? (r_acc + r_mcand) : r_acc;
  assign w_mplier_shift = r_mplier >> 1;

`ifdef SEQ_MULT_EARLY_EXIT_EN
  assign w_last = (r_cnt == CW'(WIDTH - 1)) || (w_mplier_shift == '0);
`else
  assign w_last = (r_cnt == CW'(WIDTH - 1));
`endif

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (inValid) w_state_nxt = S_CALC;
      S_CALC:  if (w_last) w_state_nxt = S_FIX;
      S_FIX:   w_state_nxt = S_DONE;
      S_DONE:  if (outReady) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      r_mcand     <= '0;
      r_acc       <= '0;
      r_mplier    <= '0;
      r_sign      <= 1'b0;
      r_cnt       <= '0;
      r_product   <= '0;
      r_out_valid <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_mcand  <= {{WIDTH{1'b0}}, w_a_mag};
            r_mplier <= w_b_mag;
            r_acc    <= '0;
            r_cnt    <= '0;
            r_sign   <= signedMode & (a[WIDTH-1] ^ b[WIDTH-1]);
          end
        end
        S_CALC: begin
          r_acc    <= w_acc_add;
          r_mcand  <= r_mcand << 1;
          r_mplier <= w_mplier_shift;
          r_cnt    <= r_cnt + CW'(1);
        end
        S_FIX: begin
          r_product   <= r_sign ? (~r_acc + PW'(1)) : r_acc;
          r_out_valid <= 1'b1;
        end
        S_DONE: begin
          if (outReady) r_out_valid <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_sequential_multiplier.sv
// tb_sequential_multiplier: directed and random checks of sequential_multiplier at WIDTH=8.
`default_nettype none

module tb_sequential_multiplier;

  localparam int WIDTH = 8;

  logic               clk;
  logic               resetN;
  logic [WIDTH-1:0]   a;
  logic [WIDTH-1:0]   b;
  logic               signedMode;
  logic               inValid;
  logic               inReady;
  logic [2*WIDTH-1:0] product;
  logic               outValid;
  logic               outReady;
  logic               busy;

  int errors = 0;
  int checks = 0;
  int n_accept = 0;
  int n_handshake = 0;

  sequential_multiplier #(.WIDTH(WIDTH)) dut (
    .clk        (clk),
    .resetN     (resetN),
    .a          (a),
    .b          (b),
    .signedMode (signedMode),
    .inValid    (inValid),
    .inReady    (inReady),
    .product    (product),
    .outValid   (outValid),
    .outReady   (outReady),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (resetN && inValid && inReady) n_accept++;
    if (resetN && outValid && outReady) n_handshake++;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: plain integer multiply of the operands as interpreted by the mode.
  function automatic logic [2*WIDTH-1:0] ref_mul(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                                                 input bit m);
    longint sx, sy;
    sx = m ? longint'($signed(x)) : longint'(x);
    sy = m ? longint'($signed(y)) : longint'(y);
    return (2*WIDTH)'(sx * sy);
  endfunction

  function automatic int ref_lat(input logic [WIDTH-1:0] y, input bit m);
`ifdef SEQ_MULT_EARLY_EXIT_EN
    int mag;
    int n;
    mag = (m && y[WIDTH-1]) ? (1 << WIDTH) - int'(y) : int'(y);
    n = 0;
    while (mag > 0) begin
      n++;
      mag = mag >> 1;
    end
    return 1 + ((n < 1) ? 1 : n);
`else
    return WIDTH + 1;
`endif
  endfunction

  // Called with inputs safe to drive (at a negedge or just after a posedge).
  task automatic run_op(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y, input bit m,
                        input int stall, input bit rnd_rdy, input bit pulse, input bit hold_chk);
    logic [2*WIDTH-1:0] exp_p;
    int lat;
    exp_p = ref_mul(x, y, m);
    check("inReady_before_accept", 64'(inReady), 64'd1);
    a = x; b = y; signedMode = m; inValid = 1'b1;
    @(posedge clk); #1;
    inValid = 1'b0;
    a = ~x; b = ~y; signedMode = ~m;
    lat = 0;
    while (!outValid && lat < 60) begin
      outReady = rnd_rdy ? 1'($urandom_range(0, 1)) : 1'b0;
      inValid = (pulse && lat == 1) ? 1'b1 : 1'b0;
      @(posedge clk); #1;
      lat++;
    end
    outReady = 1'b0;
    inValid  = 1'b0;
    check("outValid_arrives", 64'(outValid), 64'd1);
    check("latency", 64'(lat), 64'(ref_lat(y, m)));
    check("product", 64'(product), 64'(exp_p));
    for (int i = 0; i < stall; i++) begin
      @(posedge clk); #1;
      if (hold_chk) begin
        check("stall_product", 64'(product), 64'(exp_p));
        check("stall_outValid", 64'(outValid), 64'd1);
        check("stall_busy", 64'(busy), 64'd1);
        check("stall_inReady", 64'(inReady), 64'd0);
      end
    end
    outReady = 1'b1;
    @(posedge clk); #1;
    outReady = 1'b0;
    check("release_outValid", 64'(outValid), 64'd0);
    check("release_inReady", 64'(inReady), 64'd1);
    if (hold_chk) check("release_product_hold", 64'(product), 64'(exp_p));
  endtask

  initial begin
    int acc0;
    int hs0;
    logic [WIDTH-1:0] rx;
    logic [WIDTH-1:0] ry;
    bit rm;

    resetN = 1'b0; a = '0; b = '0; signedMode = 1'b0; inValid = 1'b0; outReady = 1'b0;
    #12;
    check("reset_inReady", 64'(inReady), 64'd1);
    check("reset_busy", 64'(busy), 64'd0);
    check("reset_outValid", 64'(outValid), 64'd0);
    check("reset_product", 64'(product), 64'd0);
    @(negedge clk); resetN = 1'b1;
    @(negedge clk);

    run_op(8'd255, 8'd255, 1'b0, 0, 1'b0, 1'b0, 1'b1);
    check("unsigned_max_const", 64'(product), 64'h0000_FE01);
    run_op(8'h80, 8'h80, 1'b1, 0, 1'b0, 1'b0, 1'b1);
    check("neg128_sq_const", 64'(product), 64'h4000);
    run_op(8'h80, 8'h7F, 1'b1, 0, 1'b0, 1'b0, 1'b1);
    check("neg128_x127_const", 64'(product), 64'hC080);
    run_op(8'hFF, 8'h01, 1'b1, 0, 1'b0, 1'b0, 1'b1);
    check("neg1_x1_const", 64'(product), 64'hFFFF);

    // Backpressure for five cycles with an ignored inValid pulse during CALC.
    run_op(8'd37, 8'd201, 1'b0, 5, 1'b0, 1'b1, 1'b1);

    run_op(8'd100, 8'd1, 1'b0, 0, 1'b0, 1'b0, 1'b1);
    run_op(8'd100, 8'd0, 1'b0, 0, 1'b0, 1'b0, 1'b1);
    run_op(8'd100, 8'h80, 1'b0, 0, 1'b0, 1'b0, 1'b1);
    check("b80_const", 64'(product), 64'h3200);

    // Abort during the third CALC cycle; reset must act without a clock edge.
    a = 8'd200; b = 8'd199; signedMode = 1'b0; inValid = 1'b1;
    @(posedge clk); #1;
    inValid = 1'b0;
    @(posedge clk);
    @(posedge clk); #3;
    resetN = 1'b0;
    #1;
    check("async_rst_outValid", 64'(outValid), 64'd0);
    check("async_rst_product", 64'(product), 64'd0);
    check("async_rst_inReady", 64'(inReady), 64'd1);
    check("async_rst_busy", 64'(busy), 64'd0);
    @(negedge clk);
    resetN = 1'b1;
    run_op(8'd3, 8'd5, 1'b0, 0, 1'b0, 1'b0, 1'b1);
    check("after_reset_3x5", 64'(product), 64'd15);

    acc0 = n_accept;
    hs0  = n_handshake;
    for (int i = 0; i < 2000; i++) begin
      rx = WIDTH'($urandom);
      ry = WIDTH'($urandom);
      rm = 1'($urandom_range(0, 1));
      run_op(rx, ry, rm, $urandom_range(0, 3), 1'b1, 1'b0, 1'b0);
    end
    check("handshakes_per_accept", 64'(n_handshake - hs0), 64'(n_accept - acc0));
    check("accept_count", 64'(n_accept - acc0), 64'd2000);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
